// File: rtl/uart_pkg.sv
// Shared UART definitions: standard baud rate constants and the helpers that
// turn a clock frequency, a rate and an oversample factor into a clk->tick_os
// divisor. Used at elaboration time to build the baud_sel divisor table.
package uart_pkg;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_38400  = 38400;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;
  localparam int unsigned BAUD_230400 = 230400;
  localparam int unsigned BAUD_460800 = 460800;
  localparam int unsigned BAUD_921600 = 921600;

  // Table index -> rate. Indices past the standard set reuse the fastest rate.
  function automatic int unsigned baud_rate(input int unsigned sel);
    case (sel)
      0:       return BAUD_9600;
      1:       return BAUD_19200;
      2:       return BAUD_38400;
      3:       return BAUD_57600;
      4:       return BAUD_115200;
      5:       return BAUD_230400;
      6:       return BAUD_460800;
      default: return BAUD_921600;
    endcase
  endfunction

  // round(clk_hz / (rate*os)), never below 1.
  function automatic int unsigned baud_div(input longint unsigned clk_hz,
                                           input longint unsigned rate,
                                           input longint unsigned os);
    longint unsigned den;
    longint unsigned q;
    den = rate * os;
    q   = (clk_hz + den / 2) / den;
    if (q == 0) q = 1;
    return int'(q);
  endfunction

  function automatic int unsigned baud_table_div(input longint unsigned clk_hz,
                                                 input int unsigned     sel,
                                                 input longint unsigned os);
    return baud_div(clk_hz, longint'(baud_rate(sel)), os);
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/status bundle of the baud generator.
//   master: drives en, baud_sel, use_custom, div_load, div_value, sync;
//           receives tick_os, tick_mid, tick_baud, div_active.
//   slave : the generator side.
interface uart_baud_gen_if #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
);
  logic             en;
  logic [SEL_W-1:0] baud_sel;
  logic             use_custom;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             sync;
  logic             tick_os;
  logic             tick_mid;
  logic             tick_baud;
  logic [DIV_W-1:0] div_active;

  modport master (
    output en, baud_sel, use_custom, div_load, div_value, sync,
    input  tick_os, tick_mid, tick_baud, div_active
  );

  modport slave (
    input  en, baud_sel, use_custom, div_load, div_value, sync,
    output tick_os, tick_mid, tick_baud, div_active
  );
endinterface

// File: rtl/uart_mod_counter.sv
// Modulo counter 0..mod_i-1 with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clear_i  : force count to 0 (wins over en_i), suppresses wrap_o
//   en_i     : advance one step
//   mod_i    : modulus, one bit wider than the count so 2**W is expressible
//   count_o  : current count
//   wrap_o   : combinational, high on the step that returns the count to 0
module uart_mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W:0]   mod_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  // Terminal test as (count+1 == mod) avoids subtracting from the modulus.
  assign at_last = (({1'b0, cnt_q}) + (W+1)'(1)) == mod_i;
  assign wrap_o  = en_i & ~clear_i & at_last;
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = at_last ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_baud_gen.sv
// Baud / oversample tick generator.
// clk -> tick_os every div_active cycles -> tick_baud every OVERSAMPLE tick_os,
// with tick_mid at the bit centre. The divisor comes from an elaboration-time
// rate table (baud_sel) or a runtime custom register (use_custom).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_baud_gen_if.slave (controls in, ticks/div_active out)
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int          OVERSAMPLE = 16,
  parameter int          SEL_W      = 3,
  parameter int          DIV_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_baud_gen_if.slave bus
);
  localparam int             PH_W    = $clog2(OVERSAMPLE);
  localparam logic [PH_W:0]  PH_MOD  = (PH_W+1)'(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_MID = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(baud_table_div(longint'(CLK_HZ), 0, longint'(OVERSAMPLE)));

  logic [DIV_W-1:0] tbl [2**SEL_W];

  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_tbl
    localparam int unsigned D =
      baud_table_div(longint'(CLK_HZ), g, longint'(OVERSAMPLE));
    assign tbl[g] = DIV_W'(D);
  end

  logic [DIV_W-1:0] custom_q, custom_d;
  logic [DIV_W-1:0] div_active_q;
  logic [DIV_W-1:0] eff_div;
  logic             div_chg;
  logic             clear;
  logic [DIV_W-1:0] os_cnt;
  logic [PH_W-1:0]  ph_cnt;
  logic             os_wrap, ph_wrap;
  logic             tick_os_q, tick_mid_q, tick_baud_q;
  logic             unused_os_cnt;

  assign eff_div = bus.use_custom ? custom_q : tbl[bus.baud_sel];
  // A divisor change restarts the bit phase and outranks sync; sync only
  // matters while counting.
  assign div_chg = (eff_div != div_active_q);
  assign clear   = div_chg | (bus.sync & bus.en);

  // A zero divisor would never wrap, so it is stored as 1.
  assign custom_d = (bus.div_value == '0) ? DIV_W'(1) : bus.div_value;

  uart_mod_counter #(.W(DIV_W)) u_os (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .en_i    (bus.en),
    .mod_i   ({1'b0, div_active_q}),
    .count_o (os_cnt),
    .wrap_o  (os_wrap)
  );

  uart_mod_counter #(.W(PH_W)) u_ph (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .en_i    (os_wrap),
    .mod_i   (PH_MOD),
    .count_o (ph_cnt),
    .wrap_o  (ph_wrap)
  );

  assign unused_os_cnt = ^os_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      custom_q     <= DIV_W'(1);
      div_active_q <= RST_DIV;
      tick_os_q    <= 1'b0;
      tick_mid_q   <= 1'b0;
      tick_baud_q  <= 1'b0;
    end else begin
      if (bus.div_load) custom_q <= custom_d;
      if (div_chg)      div_active_q <= eff_div;
      // os_wrap already excludes clear and en=0, so ticks drop in those cycles.
      tick_os_q   <= os_wrap;
      tick_mid_q  <= os_wrap & (ph_cnt == PH_MID);
      tick_baud_q <= ph_wrap;
    end
  end

  assign bus.tick_os    = tick_os_q;
  assign bus.tick_mid   = tick_mid_q;
  assign bus.tick_baud  = tick_baud_q;
  assign bus.div_active = div_active_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
module tb_uart_baud_gen;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  uart_baud_gen_if #(.SEL_W(3), .DIV_W(16)) bus ();

  uart_baud_gen #(
    .CLK_HZ(50_000_000), .OVERSAMPLE(16), .SEL_W(3), .DIV_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        cust;
    logic [15:0] val;
    int          exp_div;
    int          exp_os;
    int          exp_baud;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Steps until the selected tick is seen; n = steps taken, -1 on timeout.
  task automatic wait_tick(input int which, input int limit, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      step();
      n++;
      case (which)
        0:       hit = bus.tick_os;
        1:       hit = bus.tick_mid;
        default: hit = bus.tick_baud;
      endcase
    end
    if (!hit) n = -1;
  endtask

  task automatic load_custom(input logic [15:0] v);
    bus.div_value  = v;
    bus.div_load   = 1'b1;
    bus.use_custom = 1'b1;
    step();
    bus.div_load   = 1'b0;
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;

    vecs[0] = '{3'd0, 1'b0, 16'd0,  326, 326, 5216};
    vecs[1] = '{3'd1, 1'b0, 16'd0,  163, 163, 2608};
    vecs[2] = '{3'd2, 1'b0, 16'd0,   81,  81, 1296};
    vecs[3] = '{3'd3, 1'b0, 16'd0,   54,  54,  864};
    vecs[4] = '{3'd4, 1'b0, 16'd0,   27,  27,  432};
    vecs[5] = '{3'd5, 1'b0, 16'd0,   14,  14,  224};
    vecs[6] = '{3'd6, 1'b0, 16'd0,    7,   7,  112};
    vecs[7] = '{3'd7, 1'b0, 16'd0,    3,   3,   48};
    vecs[8] = '{3'd0, 1'b1, 16'd10,  10,  10,  160};
    vecs[9] = '{3'd0, 1'b1, 16'd0,    1,   1,   16};

    rst = 1'b1;
    bus.en = 1'b0; bus.baud_sel = 3'd0; bus.use_custom = 1'b0;
    bus.div_load = 1'b0; bus.div_value = 16'd0; bus.sync = 1'b0;
    step(); step();
    chk("rst_tick_os",   int'(bus.tick_os),   0);
    chk("rst_tick_baud", int'(bus.tick_baud), 0);
    chk("rst_div",       int'(bus.div_active), 326);

    // Default rate from reset
    rst = 1'b0; bus.en = 1'b1;
    wait_tick(0, 1000, n);  chk("t1_first_os", n, 326);
    wait_tick(0, 1000, n);  chk("t1_os_period", n, 326);
    wait_tick(1, 6000, n);  chk("t1_first_mid", n, 1956);
    wait_tick(2, 6000, n);  chk("t1_first_baud", n, 2608);
    wait_tick(2, 6000, n);  chk("t1_baud_period", n, 5216);

    // Rate change on the edge that would have wrapped
    repeat (325) step();
    bus.baud_sel = 3'd4;
    step();
    chk("t2_chg_no_tick", int'(bus.tick_os), 0);
    chk("t2_div", int'(bus.div_active), 27);
    wait_tick(0, 1000, n);  chk("t2_first_os", n, 27);
    wait_tick(2, 1000, n);  chk("t2_first_baud", n, 405);

    // Table-driven rate sweep
    foreach (vecs[i]) begin
      bus.baud_sel = vecs[i].sel;
      if (vecs[i].cust) load_custom(vecs[i].val);
      else bus.use_custom = 1'b0;
      repeat (3) step();
      chk($sformatf("v%0d_div", i), int'(bus.div_active), vecs[i].exp_div);
      wait_tick(0, 1000, n);
      wait_tick(0, 1000, n);
      chk($sformatf("v%0d_os", i), n, vecs[i].exp_os);
      wait_tick(2, 12000, n);
      wait_tick(2, 12000, n);
      chk($sformatf("v%0d_baud", i), n, vecs[i].exp_baud);
    end

    // sync realigns the bit phase
    load_custom(16'd10);
    repeat (3) step();
    wait_tick(0, 100, n);
    repeat (9) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("t4_sync_no_tick", int'(bus.tick_os), 0);
    wait_tick(1, 500, n);  chk("t4_mid_after_sync", n, 80);
    wait_tick(2, 500, n);  chk("t4_baud_after_mid", n, 80);

    // sync together with a divisor change
    bus.baud_sel = 3'd7; bus.use_custom = 1'b0; bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("t4b_div", int'(bus.div_active), 3);
    chk("t4b_no_tick", int'(bus.tick_os), 0);
    wait_tick(0, 100, n);  chk("t4b_first_os", n, 3);
    wait_tick(1, 100, n);  chk("t4b_first_mid", n, 21);

    // en low holds the count
    bus.baud_sel = 3'd4;
    repeat (2) step();
    wait_tick(0, 100, n);
    repeat (10) step();
    bus.en = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.tick_os || bus.tick_mid || bus.tick_baud) seen++;
    end
    chk("t5_ticks_while_off", seen, 0);
    bus.en = 1'b1;
    wait_tick(0, 200, n);  chk("t5_resume_os", n, 17);

    // async reset mid-cycle
    load_custom(16'd1);
    repeat (4) step();
    chk("t6_pre_tick", int'(bus.tick_os), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_tick", int'(bus.tick_os), 0);
    chk("t6_async_div", int'(bus.div_active), 326);
    bus.use_custom = 1'b0; bus.baud_sel = 3'd0;
    step();
    rst = 1'b0;
    wait_tick(0, 1000, n);  chk("t6_first_os", n, 326);
    bus.use_custom = 1'b1;
    repeat (2) step();
    chk("t6_custom_rst", int'(bus.div_active), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
